store_buffer: RTL

Multi-sample successor to the single-value delayed store unit. After a programmable start delay it captures `in0` into a DEPTH-entry ring of registers, one sample every `period0 + 1` active cycles, for `count0` samples, then raises `done`. It sits in the Versat datapath as a configurable sink. The most recent sample is always visible on `currentValue`, and any stored entry can be read back through a registered read port.

---
 rtl/store_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// store_buffer: delayed, periodic multi-sample capture of in0 into a ring of
// DEPTH registers, with the latest sample on currentValue and a registered
// read-before-write readback port.
module store_buffer #(
   parameter int DELAY_W = 32,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               running,
   input  logic               run,
   output logic               done,
   input  logic [DATA_W-1:0]  in0,
   input  logic [DELAY_W-1:0] delay0,
   input  logic [DELAY_W-1:0] period0,
   input  logic [DELAY_W-1:0] count0,
   input  logic [ADDR_W-1:0]  rdAddr,
   output logic [DATA_W-1:0]  rdData,
   output logic [DATA_W-1:0]  currentValue,
   output logic [DELAY_W-1:0] sampleCount
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [DELAY_W-1:0] CNT_ONE = DELAY_W'(1);
   localparam logic [ADDR_W-1:0]  PTR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DELAY   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [DELAY_W-1:0] delayCnt_q, delayCnt_d;
   logic [DELAY_W-1:0] periodCnt_q, periodCnt_d;
   logic [DELAY_W-1:0] periodLat_q, periodLat_d;
   logic [DELAY_W-1:0] countLat_q, countLat_d;
   logic [DELAY_W-1:0] sampleCount_q, sampleCount_d;
   logic [ADDR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [DATA_W-1:0]  currentValue_q, currentValue_d;
   logic               done_q, done_d;
   logic               capture;
   logic [DATA_W-1:0]  ring_q [DEPTH];
   logic [DATA_W-1:0]  rdData_q;

   // Next-state logic: run restarts everything, otherwise advance only while running.
   always_comb begin
      state_d        = state_q;
      delayCnt_d     = delayCnt_q;
      periodCnt_d    = periodCnt_q;
      periodLat_d    = periodLat_q;
      countLat_d     = countLat_q;
      sampleCount_d  = sampleCount_q;
      wrPtr_d        = wrPtr_q;
      currentValue_d = currentValue_q;
      done_d         = done_q;
      capture        = 1'b0;

      if (run) begin
         periodLat_d   = period0;
         countLat_d    = count0;
         delayCnt_d    = delay0;
         wrPtr_d       = '0;
         sampleCount_d = '0;
         if (count0 == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else begin
            state_d = DELAY;
            done_d  = 1'b0;
         end
      end else if (running) begin
         case (state_q)
            DELAY: begin
               if (delayCnt_q != '0) begin
                  delayCnt_d = delayCnt_q - CNT_ONE;
               end else begin
                  capture = 1'b1;
                  state_d = CAPTURE;
               end
            end
            CAPTURE: begin
               if (periodCnt_q != '0) begin
                  periodCnt_d = periodCnt_q - CNT_ONE;
               end else if (sampleCount_q < countLat_q) begin
                  capture = 1'b1;
               end
            end
            default: ;
         endcase

         if (capture) begin
            currentValue_d = in0;
            wrPtr_d        = wrPtr_q + PTR_ONE;
            sampleCount_d  = sampleCount_q + CNT_ONE;
            periodCnt_d    = periodLat_q;
            if (sampleCount_q + CNT_ONE == countLat_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
      end
   end

   // Control and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         delayCnt_q     <= '0;
         periodCnt_q    <= '0;
         periodLat_q    <= '0;
         countLat_q     <= '0;
         sampleCount_q  <= '0;
         wrPtr_q        <= '0;
         currentValue_q <= '0;
         done_q         <= 1'b1;
      end else begin
         state_q        <= state_d;
         delayCnt_q     <= delayCnt_d;
         periodCnt_q    <= periodCnt_d;
         periodLat_q    <= periodLat_d;
         countLat_q     <= countLat_d;
         sampleCount_q  <= sampleCount_d;
         wrPtr_q        <= wrPtr_d;
         currentValue_q <= currentValue_d;
         done_q         <= done_d;
      end
   end

   // Ring storage and readback; nonblocking read gives read-before-write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ring_q[i] <= '0;
         end
         rdData_q <= '0;
      end else begin
         if (capture) begin
            ring_q[wrPtr_q] <= in0;
         end
         rdData_q <= ring_q[rdAddr];
      end
   end

   assign done         = done_q;
   assign currentValue = currentValue_q;
   assign sampleCount  = sampleCount_q;
   assign rdData       = rdData_q;

endmodule
